// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_RET = 2'd1,
    S_INT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-field inputs and stall/flush/forward controls of hazard_ctrl.
interface hazard_ctrl_if #(parameter int REG_AW = 2);

  logic [REG_AW-1:0] ra_D, rb_D, ra_E, rb_E, rd_E, rd_M, rd_W;
  logic              use_ra_D, use_rb_D;
  logic              wr_en_regf_E, wr_en_regf_M, wr_en_regf_W;
  logic              rd_en_E, branch_taken_E, is_ret_E, intr_req;
  logic              stall_F, stall_D, flush_D, flush_E;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic              intr_ack, pc_src_intr, busy;

  modport master (
    output ra_D, rb_D, ra_E, rb_E, rd_E, rd_M, rd_W, use_ra_D, use_rb_D,
           wr_en_regf_E, wr_en_regf_M, wr_en_regf_W, rd_en_E, branch_taken_E,
           is_ret_E, intr_req,
    input  stall_F, stall_D, flush_D, flush_E, fwd_a_sel, fwd_b_sel,
           intr_ack, pc_src_intr, busy
  );

  modport slave (
    input  ra_D, rb_D, ra_E, rb_E, rd_E, rd_M, rd_W, use_ra_D, use_rb_D,
           wr_en_regf_E, wr_en_regf_M, wr_en_regf_W, rd_en_E, branch_taken_E,
           is_ret_E, intr_req,
    output stall_F, stall_D, flush_D, flush_E, fwd_a_sel, fwd_b_sel,
           intr_ack, pc_src_intr, busy
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-operand forwarding comparator; with EN=0 both selects stay on the register file.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 2,
  parameter bit EN     = 1'b1
) (
  input  logic [REG_AW-1:0] ra_e_i,
  input  logic [REG_AW-1:0] rb_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              wr_m_i,
  input  logic              wr_w_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // The younger producer in M holds the newer value, so it wins over W.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] src);
    if (wr_m_i && (rd_m_i == src)) return FWD_M;
    if (wr_w_i && (rd_w_i == src)) return FWD_W;
    return FWD_RF;
  endfunction

  assign fwd_a_o = EN ? pick(ra_e_i) : FWD_RF;
  assign fwd_b_o = EN ? pick(rb_e_i) : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/redirect controller: load-use and RAW stalls, RET and interrupt bubble sequencing.
// Define HAZARD_FWD_EN to enable EX-operand forwarding (otherwise RAW hazards stall).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 2,
  parameter int unsigned RET_BUBBLES = 2,
  parameter int unsigned INTR_CYCLES = 3
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(max2(RET_BUBBLES, INTR_CYCLES) + 1);

  if (RET_BUBBLES == 0 || INTR_CYCLES == 0) begin : g_bad_params
    $error("hazard_ctrl: RET_BUBBLES and INTR_CYCLES must be non-zero");
  end

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             init_q;
  logic             live;
  logic             dep_e, dep_m, load_use, data_stall;
  logic             stall_f, stall_d, flush_d, flush_e, ack, pc_intr;
  logic [1:0]       fwd_a, fwd_b;

  fwd_unit #(.REG_AW(REG_AW), .EN(FWD_EN)) u_fwd (
    .ra_e_i (hz.ra_E),
    .rb_e_i (hz.rb_E),
    .rd_m_i (hz.rd_M),
    .rd_w_i (hz.rd_W),
    .wr_m_i (hz.wr_en_regf_M),
    .wr_w_i (hz.wr_en_regf_W),
    .fwd_a_o(fwd_a),
    .fwd_b_o(fwd_b)
  );

  // W needs no check: the register file writes through to decode reads.
  assign dep_e = (hz.use_ra_D && hz.ra_D == hz.rd_E) || (hz.use_rb_D && hz.rb_D == hz.rd_E);
  assign dep_m = (hz.use_ra_D && hz.ra_D == hz.rd_M) || (hz.use_rb_D && hz.rb_D == hz.rd_M);
  assign load_use   = hz.rd_en_E && hz.wr_en_regf_E && dep_e;
  assign data_stall = FWD_EN ? load_use
                             : ((hz.wr_en_regf_E && dep_e) || (hz.wr_en_regf_M && dep_m));

  // init_q keeps the block quiet for the first cycle after reset release.
  assign live = !reset && !init_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      init_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      init_q    <= 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | hz.intr_req;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    ack       = 1'b0;
    pc_intr   = 1'b0;
    if (init_q) begin
      pending_d = pending_q;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hz.is_ret_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            cnt_d   = CNT_W'(RET_BUBBLES);
            state_d = S_RET;
          end else if (hz.branch_taken_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (data_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (pending_q) begin
            ack       = 1'b1;
            cnt_d     = CNT_W'(INTR_CYCLES);
            pending_d = 1'b0;
            state_d   = S_INT;
          end
        end
        S_RET, S_INT: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          pc_intr = (state_q == S_INT);
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  assign hz.stall_F     = live && stall_f;
  assign hz.stall_D     = live && stall_d;
  assign hz.flush_D     = live && flush_d;
  assign hz.flush_E     = live && flush_e;
  assign hz.intr_ack    = live && ack;
  assign hz.pc_src_intr = live && pc_intr;
  assign hz.busy        = live && (state_q != S_RUN);
  assign hz.fwd_a_sel   = live ? fwd_a : FWD_RF;
  assign hz.fwd_b_sel   = live ? fwd_b : FWD_RF;

endmodule
